division_32_param: RTL and testbench

- Parametrised sequential integer divider; successor to the fixed 32-bit unsigned divider in the ALU.
- Supports run-time signed/unsigned mode, configurable operand width, explicit busy output, and defined divide-by-zero and signed-overflow results.
- Sits beside the multiplier in the ALU and is driven by the execute-stage controller via a start/finish handshake.
- Restoring algorithm, one quotient bit per clock.

---
 rtl/division_32_param.sv | 181 ++++++++++++++++++
 tb/tb_division_32_param.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/division_32_param.sv
`default_nettype none
// ============================================================================
// Module      : division_32_param
// Description : Sequential restoring integer divider, one quotient bit per
//               clock. Run-time signed/unsigned mode, start/finish handshake,
//               defined divide-by-zero and signed-overflow results.
//               result = {remainder, quotient}.
// Revision    : 1.0 - initial release
// ============================================================================
module division_32_param #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               sign_mode,
  input  logic [WIDTH-1:0]   operand1,
  input  logic [WIDTH-1:0]   operand2,
  output logic [2*WIDTH-1:0] result,
  output logic               finish,
  output logic               busy,
  output logic               illegal,
  output logic               overflow
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO     = '0;
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0]     div_q, div_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 neg_quo_q, neg_quo_d;
  logic                 neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 finish_q, finish_d;
  logic                 busy_q, busy_d;
  logic                 illegal_q, illegal_d;
  logic                 overflow_q, overflow_d;

  // Datapath helpers: operand signs/magnitudes and the trial subtraction.
  logic                 op1_neg, op2_neg;
  logic [WIDTH-1:0]     op1_abs, op2_abs;
  logic [WIDTH:0]       trial;
  logic [WIDTH:0]       rem_shift;

  assign op1_neg   = sign_mode & operand1[WIDTH-1];
  assign op2_neg   = sign_mode & operand2[WIDTH-1];
  // |MIN| keeps the MIN bit pattern, which is the correct unsigned magnitude.
  assign op1_abs   = op1_neg ? (~operand1 + ONE) : operand1;
  assign op2_abs   = op2_neg ? (~operand2 + ONE) : operand2;
  assign rem_shift = {rem_q, quo_q[WIDTH-1]};
  assign trial     = rem_shift - {1'b0, div_q};

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      quo_q      <= '0;
      div_q      <= '0;
      cnt_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      finish_q   <= 1'b0;
      busy_q     <= 1'b0;
      illegal_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      finish_q   <= finish_d;
      busy_q     <= busy_d;
      illegal_q  <= illegal_d;
      overflow_q <= overflow_d;
    end
  end

  // Next-state logic: accept/short-cut, one restoring step per CALC cycle,
  // sign fix-up, then a single-cycle finish pulse.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    div_d      = div_q;
    cnt_d      = cnt_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    finish_d   = 1'b0;
    busy_d     = busy_q;
    illegal_d  = illegal_q;
    overflow_d = overflow_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          busy_d     = 1'b1;
          illegal_d  = 1'b0;
          overflow_d = 1'b0;
          if (operand2 == ZERO) begin
            illegal_d = 1'b1;
            result_d  = {operand1, ALL_ONES};
            state_d   = DONE;
          end else if (sign_mode && (operand1 == MIN_VAL) && (operand2 == ALL_ONES)) begin
            overflow_d = 1'b1;
            result_d   = {ZERO, MIN_VAL};
            state_d    = DONE;
          end else begin
            rem_d     = ZERO;
            quo_d     = op1_abs;
            div_d     = op2_abs;
            cnt_d     = CNT_LAST;
            neg_quo_d = op1_neg ^ op2_neg;
            neg_rem_d = op1_neg;
            state_d   = CALC;
          end
        end
      end

      CALC: begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_shift[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      FIX: begin
        result_d = {(neg_rem_q ? (~rem_q + ONE) : rem_q),
                    (neg_quo_q ? (~quo_q + ONE) : quo_q)};
        state_d  = DONE;
      end

      DONE: begin
        finish_d = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign result   = result_q;
  assign finish   = finish_q;
  assign busy     = busy_q;
  assign illegal  = illegal_q;
  assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_division_32_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_division_32_param
// Description : Self-checking bench for division_32_param at WIDTH=32 and
//               WIDTH=8: directed vector table, hand-written multi-cycle
//               sequences and randomized operations against an arithmetic
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_division_32_param;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start32, start8, sm;
  logic [31:0] op1, op2;

  logic [63:0] res32;
  logic        fin32, busy32, ill32, ovf32;
  logic [15:0] res8;
  logic        fin8, busy8, ill8, ovf8;

  int checks = 0;
  int errors = 0;

  bit          cur8;
  logic [63:0] w_res;
  logic        w_fin, w_busy, w_ill, w_ovf;
  logic [63:0] prev_res [2];

  always #5 clk = ~clk;

  division_32_param #(.WIDTH(32)) u_div32 (
    .clock(clk), .reset_n(reset_n), .start(start32), .sign_mode(sm),
    .operand1(op1), .operand2(op2), .result(res32), .finish(fin32),
    .busy(busy32), .illegal(ill32), .overflow(ovf32)
  );

  division_32_param #(.WIDTH(8)) u_div8 (
    .clock(clk), .reset_n(reset_n), .start(start8), .sign_mode(sm),
    .operand1(op1[7:0]), .operand2(op2[7:0]), .result(res8), .finish(fin8),
    .busy(busy8), .illegal(ill8), .overflow(ovf8)
  );

  assign w_res  = cur8 ? {48'd0, res8} : res32;
  assign w_fin  = cur8 ? fin8  : fin32;
  assign w_busy = cur8 ? busy8 : busy32;
  assign w_ill  = cur8 ? ill8  : ill32;
  assign w_ovf  = cur8 ? ovf8  : ovf32;

  typedef struct {
    bit          w8;
    bit          sm;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] er;
    bit          ei;
    bit          eo;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Truncating division from plain arithmetic on w-bit operands.
  function automatic void model(input int w, input bit smode,
                                input longint unsigned a, input longint unsigned b,
                                output longint unsigned q, output longint unsigned r,
                                output bit ill, output bit ovf);
    longint unsigned mask, minv;
    longint sa, sb;
    mask = (64'd1 << w) - 64'd1;
    minv = 64'd1 << (w - 1);
    ill = 1'b0;
    ovf = 1'b0;
    if (b == 0) begin
      ill = 1'b1; q = mask; r = a;
    end else if (smode && a == minv && b == mask) begin
      ovf = 1'b1; q = minv; r = 0;
    end else if (smode) begin
      sa = longint'(a ^ minv) - longint'(minv);
      sb = longint'(b ^ minv) - longint'(minv);
      q  = longint'(sa / sb) & mask;
      r  = longint'(sa % sb) & mask;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic wait_fin(output int lat, output bit busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    while (!w_fin && lat < 200) begin
      if (!w_busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run(input bit w8, input bit smode, input logic [31:0] a,
                     input logic [31:0] b, input logic [63:0] er,
                     input bit ei, input bit eo, input string nm);
    int lat, elat;
    bit busy_ok;
    elat = (ei || eo) ? 1 : (w8 ? 10 : 34);
    @(negedge clk);
    cur8 = w8; sm = smode; op1 = a; op2 = b;
    if (w8) start8 = 1'b1; else start32 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; start32 = 1'b0;
    op1 = $urandom; op2 = $urandom; sm = 1'($urandom_range(0, 1));
    chk({nm, " busy@accept"}, 64'(w_busy), 64'd1);
    chk({nm, " flags@accept"}, 64'({w_ill, w_ovf}), 64'({ei, eo}));
    if (!(ei || eo)) chk({nm, " result held@accept"}, w_res, prev_res[w8]);
    wait_fin(lat, busy_ok);
    chk({nm, " latency"}, 64'(lat), 64'(elat));
    chk({nm, " busy throughout"}, 64'(busy_ok), 64'd1);
    chk({nm, " result"}, w_res, er);
    chk({nm, " flags"}, 64'({w_ill, w_ovf}), 64'({ei, eo}));
    chk({nm, " busy@finish"}, 64'(w_busy), 64'd0);
    @(posedge clk); #1;
    chk({nm, " finish pulse"}, 64'(w_fin), 64'd0);
    chk({nm, " result hold"}, w_res, er);
    chk({nm, " flags hold"}, 64'({w_ill, w_ovf}), 64'({ei, eo}));
    prev_res[w8] = er;
  endtask

  initial begin
    int lat;
    bit busy_ok, ei, eo, smode, w8;
    logic [31:0] a, b, mask;
    longint unsigned q, r;
    logic [63:0] er;

    reset_n = 1'b0; start32 = 1'b0; start8 = 1'b0; sm = 1'b0;
    op1 = '0; op2 = '0; cur8 = 1'b0;
    prev_res[0] = '0; prev_res[1] = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset result32", res32, 64'd0);
    chk("reset result8", {48'd0, res8}, 64'd0);
    chk("reset status", 64'({fin32, busy32, ill32, ovf32, fin8, busy8, ill8, ovf8}), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed vectors with hand-derived expectations.
    tbl[0]  = '{0, 0, 32'h10000000, 32'h10,       {32'h0, 32'h01000000},        0, 0};
    tbl[1]  = '{0, 0, 32'd2222,     32'd2,        {32'd0, 32'd1111},            0, 0};
    tbl[2]  = '{0, 0, 32'd200,      32'd0,        {32'd200, 32'hFFFFFFFF},      1, 0};
    tbl[3]  = '{0, 1, 32'd200,      32'd0,        {32'd200, 32'hFFFFFFFF},      1, 0};
    tbl[4]  = '{0, 1, 32'hFFFFFFF9, 32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD}, 0, 0};
    tbl[5]  = '{0, 1, 32'd7,        32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD},        0, 0};
    tbl[6]  = '{0, 0, 32'hFFFFFFF9, 32'd2,        {32'd1, 32'h7FFFFFFC},        0, 0};
    tbl[7]  = '{0, 1, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000},        0, 1};
    tbl[8]  = '{0, 0, 32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'd0},        0, 0};
    tbl[9]  = '{1, 0, 32'd200,      32'd7,        {48'd0, 8'd4, 8'd28},         0, 0};
    tbl[10] = '{1, 1, 32'h80,       32'hFF,       {48'd0, 8'd0, 8'h80},         0, 1};
    tbl[11] = '{0, 1, 32'hFFFFFFF9, 32'd0,        {32'hFFFFFFF9, 32'hFFFFFFFF}, 1, 0};

    for (int i = 0; i < 12; i++) begin
      run(tbl[i].w8, tbl[i].sm, tbl[i].a, tbl[i].b, tbl[i].er, tbl[i].ei, tbl[i].eo,
          $sformatf("vec%0d", i));
    end

    // Start held high: second operation accepted right after DONE; operand
    // changes during the first operation must be ignored.
    cur8 = 1'b0;
    @(negedge clk);
    sm = 1'b0; op1 = 32'd2222; op2 = 32'd2; start32 = 1'b1;
    @(posedge clk); #1;
    op1 = 32'd5; op2 = 32'd1;
    wait_fin(lat, busy_ok);
    chk("b2b first latency", 64'(lat), 64'd34);
    chk("b2b first result", res32, {32'd0, 32'd1111});
    op1 = 32'd7; op2 = 32'd3;
    @(posedge clk); #1;
    chk("b2b second accepted", 64'(busy32), 64'd1);
    start32 = 1'b0;
    wait_fin(lat, busy_ok);
    chk("b2b second latency", 64'(lat), 64'd34);
    chk("b2b second busy", 64'(busy_ok), 64'd1);
    chk("b2b second result", res32, {32'd1, 32'd2});
    prev_res[0] = {32'd1, 32'd2};

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    sm = 1'b0; op1 = 32'h12345678; op2 = 32'd3; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async reset result", res32, 64'd0);
    chk("async reset status", 64'({fin32, busy32, ill32, ovf32}), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    prev_res[0] = '0;
    prev_res[1] = '0;
    run(0, 0, 32'h12345678, 32'd3, {32'd0, 32'd101806632}, 0, 0, "after reset");

    // Randomized operations on both widths against the reference model.
    for (int i = 0; i < 160; i++) begin
      w8    = (i % 4 == 3);
      mask  = w8 ? 32'hFF : 32'hFFFFFFFF;
      smode = 1'($urandom_range(0, 1));
      a     = $urandom & mask;
      b     = $urandom & mask;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = w8 ? 32'h80 : 32'h80000000; b = mask; end
        2: b = $urandom_range(1, 15);
        3: a = $urandom_range(0, 15);
        default: ;
      endcase
      model(w8 ? 8 : 32, smode, 64'(a), 64'(b), q, r, ei, eo);
      if (w8) er = {48'd0, r[7:0], q[7:0]};
      else    er = {r[31:0], q[31:0]};
      run(w8, smode, a, b, er, ei, eo, $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
